// File: rtl/md_ctrl_if.sv
// EX-side bundle for the multiply/divide sequencer: op issue, stall/busy status, HI/LO writes.
interface md_ctrl_if;
    logic        flush;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stallreq;
    logic        busy;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    modport master (
        output flush, op_valid, op, src_a, src_b,
        input  stallreq, busy, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  flush, op_valid, op, src_a, src_b,
        output stallreq, busy, hi_we, lo_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer beside EX; sole writer of the HI/LO pair.
// Shift-add multiplier and restoring divider on magnitudes, signs fixed up at the end.
module md_ctrl #(
    parameter int unsigned ITER   = 32,
    parameter logic [31:0] DIV0_Q = 32'hFFFF_FFFF
) (
    input  logic      clk,
    input  logic      rst,
    md_ctrl_if.slave  md
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    op_a, op_b, a_raw;
    logic            sign_q, sign_r, div0;
    logic [W-1:0]    res_hi, res_lo;
    logic            busy_q;

    logic            is_mul_c, is_div_c, is_signed_c, accept_c, last_c;
    logic [W-1:0]    abs_a_c, abs_b_c;
    logic [2*W-1:0]  mul_acc_c, mul_res_c;
    logic [W:0]      shl_c, diff_c;
    logic            ge_c;
    logic [2*W-1:0]  div_acc_c;
    logic [W-1:0]    quo_c, rem_c;

    // Operand decode and magnitude extraction for the acceptance cycle
    always_comb begin
        is_mul_c    = (md.op == OP_MULT) || (md.op == OP_MULTU);
        is_div_c    = (md.op == OP_DIV)  || (md.op == OP_DIVU);
        is_signed_c = (md.op == OP_MULT) || (md.op == OP_DIV);
        accept_c    = (state == S_IDLE) && md.op_valid && !md.flush && (is_mul_c || is_div_c);
        abs_a_c     = (is_signed_c && md.src_a[W-1]) ? W'(-md.src_a) : md.src_a;
        abs_b_c     = (is_signed_c && md.src_b[W-1]) ? W'(-md.src_b) : md.src_b;
        last_c      = (cnt == CW'(ITER - 1));
    end

    // One iteration of each datapath; the divider keeps a 33-bit partial remainder
    always_comb begin
        mul_acc_c = acc + (op_b[cnt[4:0]] ? ((2*W)'(op_a) << cnt) : '0);
        mul_res_c = sign_q ? (2*W)'(-mul_acc_c) : mul_acc_c;
        shl_c     = {acc[2*W-1:W], acc[W-1]};
        ge_c      = (shl_c >= {1'b0, op_b});
        diff_c    = shl_c - {1'b0, op_b};
        div_acc_c = {(ge_c ? diff_c[W-1:0] : shl_c[W-1:0]), acc[W-2:0], ge_c};
        quo_c     = div_acc_c[W-1:0];
        rem_c     = div_acc_c[2*W-1:W];
    end

    always_comb begin
        next_state = state;
        if (md.flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept_c) next_state = is_mul_c ? S_MUL : S_DIV;
                S_MUL:   if (last_c)   next_state = S_DONE;
                S_DIV:   if (last_c)   next_state = S_DONE;
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            a_raw  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state == S_MUL) || (next_state == S_DIV);
            case (state)
                S_IDLE: if (accept_c) begin
                    op_a   <= abs_a_c;
                    op_b   <= abs_b_c;
                    a_raw  <= md.src_a;
                    sign_q <= is_signed_c && (md.src_a[W-1] ^ md.src_b[W-1]);
                    sign_r <= (md.op == OP_DIV) && md.src_a[W-1];
                    div0   <= is_div_c && (md.src_b == '0);
                    cnt    <= '0;
                    acc    <= is_mul_c ? '0 : (2*W)'(abs_a_c);
                end
                S_MUL: begin
                    acc <= mul_acc_c;
                    cnt <= cnt + CW'(1);
                    if (last_c) {res_hi, res_lo} <= mul_res_c;
                end
                S_DIV: begin
                    acc <= div_acc_c;
                    cnt <= cnt + CW'(1);
                    if (last_c) begin
                        // Divide-by-zero still runs the full length; only the result is overridden
                        if (div0) begin
                            res_lo <= DIV0_Q;
                            res_hi <= a_raw;
                        end else begin
                            res_lo <= sign_q ? W'(-quo_c) : quo_c;
                            res_hi <= sign_r ? W'(-rem_c) : rem_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write/stall outputs; flush kills every write and the stall, reset zeroes everything
    always_comb begin
        md.stallreq = 1'b0;
        md.hi_we    = 1'b0;
        md.lo_we    = 1'b0;
        md.hi_wdata = '0;
        md.lo_wdata = '0;
        md.busy     = busy_q;
        case (state)
            S_IDLE: if (md.op_valid && !md.flush) begin
                if (md.op == OP_MTHI) begin
                    md.hi_we    = 1'b1;
                    md.hi_wdata = md.src_a;
                end
                if (md.op == OP_MTLO) begin
                    md.lo_we    = 1'b1;
                    md.lo_wdata = md.src_a;
                end
                md.stallreq = accept_c;
            end
            S_MUL, S_DIV: md.stallreq = !md.flush;
            S_DONE: begin
                md.hi_we    = !md.flush;
                md.lo_we    = !md.flush;
                md.hi_wdata = res_hi;
                md.lo_wdata = res_lo;
            end
            default: ;
        endcase
        if (!rst) begin
            md.stallreq = 1'b0;
            md.hi_we    = 1'b0;
            md.lo_we    = 1'b0;
            md.hi_wdata = '0;
            md.lo_wdata = '0;
            md.busy     = 1'b0;
        end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed plan vectors, random mul/div against an arithmetic model,
// mthi/mtlo, flush and mid-operation reset.
module tb_md_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    md_ctrl_if bus ();

    md_ctrl u_dut (
        .clk (clk),
        .rst (rst_n),
        .md  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'b001: return 64'(sa * sb);
            3'b010: return {32'h0, a} * {32'h0, b};
            3'b011, 3'b100: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 3'b011) begin
                    q = sa / sb;
                    r = sa % sb;
                    qv = 64'(q);
                    rv = 64'(r);
                end else begin
                    qv = {32'h0, a} / {32'h0, b};
                    rv = {32'h0, a} % {32'h0, b};
                end
                return {rv[31:0], qv[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Issue one mul/div op and observe it to completion (no comparisons here)
    task automatic do_md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output int stalls,
                            output int we_cyc, output bit tmo, output bit proto_bad);
        int c;
        bit done;
        stalls = 0; we_cyc = 0; tmo = 0; proto_bad = 0; done = 0; hi = '0; lo = '0;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        #1;
        if (bus.busy) proto_bad = 1;
        c = 0;
        while (!done && c < 80) begin
            if (bus.hi_we && bus.lo_we) begin
                hi = bus.hi_wdata; lo = bus.lo_wdata;
                we_cyc++;
                done = 1;
                if (bus.busy || bus.stallreq) proto_bad = 1;
                bus.op_valid = 1'b0; bus.op = 3'b000;
            end else begin
                if (bus.stallreq) stalls++;
                if (c > 0 && !bus.busy) proto_bad = 1;
                if (bus.hi_we || bus.lo_we) proto_bad = 1;
            end
            @(negedge clk); #1;
            c++;
        end
        tmo = !done;
        if (bus.hi_we || bus.lo_we) we_cyc++;
        bus.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.op_valid = 1'b1; bus.op = 3'b101;
        bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h0;
        #12;
        n_cmp++;
        if ({bus.stallreq, bus.busy, bus.hi_we, bus.lo_we} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.stallreq, bus.busy, bus.hi_we, bus.lo_we});
        end
        n_cmp++;
        if ({bus.hi_wdata, bus.lo_wdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {bus.hi_wdata, bus.lo_wdata});
        end
        bus.op_valid = 1'b0; bus.op = 3'b000;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  ops [8] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001};
        logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'd2,
                                 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000};
        logic [63:0] ex  [8] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0002_0000_000E,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000, 64'h1234_5678_FFFF_FFFF,
                                 64'hFFFF_FFF9_FFFF_FFFF, 64'h4000_0000_0000_0000};
        logic [31:0] hi, lo;
        int stalls, we_cyc;
        bit tmo, pb;
        for (int i = 0; i < 8; i++) begin
            do_md_op(ops[i], as[i], bs[i], hi, lo, stalls, we_cyc, tmo, pb);
            n_cmp++;
            if (tmo) begin n_bad++; $display("FAIL dir%0d_timeout: no HI/LO write within bound", i); end
            n_cmp++;
            if ({hi, lo} !== ex[i]) begin
                n_bad++; $display("FAIL dir%0d_result: got hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, ex[i][63:32], ex[i][31:0]);
            end
            n_cmp++;
            if (stalls !== 33) begin n_bad++; $display("FAIL dir%0d_stall: got %0d cycles expected 33", i, stalls); end
            n_cmp++;
            if (we_cyc !== 1) begin n_bad++; $display("FAIL dir%0d_we_len: got %0d cycles expected 1", i, we_cyc); end
            n_cmp++;
            if (pb) begin n_bad++; $display("FAIL dir%0d_busy: busy/stall/we sequencing wrong, got 1 expected 0", i); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int stalls, we_cyc;
        bit tmo, pb;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp = ref_md(op, a, b);
            do_md_op(op, a, b, hi, lo, stalls, we_cyc, tmo, pb);
            n_cmp++;
            if (tmo || {hi, lo} !== exp || stalls != 33 || we_cyc != 1 || pb) begin
                n_bad++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got hi=%h lo=%h stall=%0d we=%0d tmo=%0d pb=%0d expected hi=%h lo=%h stall=33 we=1",
                         i, op, a, b, hi, lo, stalls, we_cyc, tmo, pb, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b101; bus.src_a = 32'hCAFE_BABE; bus.src_b = 32'h1;
        #1;
        n_cmp++;
        if ({bus.hi_we, bus.lo_we, bus.stallreq, bus.busy, bus.hi_wdata} !== {4'b1000, 32'hCAFE_BABE}) begin
            n_bad++; $display("FAIL mthi: got we=%b%b stall=%b busy=%b hi=%h expected we=10 stall=0 busy=0 hi=cafebabe",
                              bus.hi_we, bus.lo_we, bus.stallreq, bus.busy, bus.hi_wdata);
        end
        @(negedge clk);
        bus.op = 3'b110; bus.src_a = 32'h0BAD_F00D;
        #1;
        n_cmp++;
        if ({bus.hi_we, bus.lo_we, bus.stallreq, bus.busy, bus.lo_wdata} !== {4'b0100, 32'h0BAD_F00D}) begin
            n_bad++; $display("FAIL mtlo: got we=%b%b stall=%b busy=%b lo=%h expected we=01 stall=0 busy=0 lo=0badf00d",
                              bus.hi_we, bus.lo_we, bus.stallreq, bus.busy, bus.lo_wdata);
        end
        @(negedge clk);
        bus.flush = 1'b1; bus.op = 3'b101;
        #1;
        n_cmp++;
        if ({bus.hi_we, bus.lo_we, bus.stallreq} !== 3'b000) begin
            n_bad++; $display("FAIL mthi_flush: got we=%b%b stall=%b expected 000", bus.hi_we, bus.lo_we, bus.stallreq);
        end
        @(negedge clk);
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op = 3'b000;
    endtask

    task automatic test_flush();
        int we_seen;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b011; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        n_cmp++;
        if ({bus.stallreq, bus.hi_we, bus.lo_we} !== 3'b000) begin
            n_bad++; $display("FAIL flush_cycle: got stall/we=%b expected 000", {bus.stallreq, bus.hi_we, bus.lo_we});
        end
        @(negedge clk);
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op = 3'b000;
        #1;
        n_cmp++;
        if ({bus.busy, bus.stallreq} !== 2'b00) begin
            n_bad++; $display("FAIL flush_idle: got busy/stall=%b expected 00", {bus.busy, bus.stallreq});
        end
        we_seen = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (bus.hi_we || bus.lo_we || bus.busy) we_seen++;
        end
        n_cmp++;
        if (we_seen !== 0) begin n_bad++; $display("FAIL flush_nowrite: got %0d active cycles expected 0", we_seen); end
    endtask

    task automatic test_reset_mid();
        int we_seen;
        we_seen = 0;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b001; bus.src_a = 32'h0001_2345; bus.src_b = 32'hFFFF_0003;
        repeat (20) begin
            @(negedge clk); #1;
            if (bus.hi_we || bus.lo_we) we_seen++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.stallreq, bus.busy, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata} !== 68'h0) begin
            n_bad++; $display("FAIL rst_mid: got stall=%b busy=%b we=%b%b hi=%h lo=%h expected all 0",
                              bus.stallreq, bus.busy, bus.hi_we, bus.lo_we, bus.hi_wdata, bus.lo_wdata);
        end
        bus.op_valid = 1'b0; bus.op = 3'b000;
        @(negedge clk); rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk); #1;
            if (bus.hi_we || bus.lo_we) we_seen++;
        end
        n_cmp++;
        if (we_seen !== 0) begin n_bad++; $display("FAIL rst_nowrite: got %0d write cycles expected 0", we_seen); end
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b110; bus.src_a = 32'h5A5A_1234;
        #1;
        n_cmp++;
        if ({bus.lo_we, bus.hi_we, bus.stallreq, bus.lo_wdata} !== {3'b100, 32'h5A5A_1234}) begin
            n_bad++; $display("FAIL rst_then_mtlo: got lo_we=%b hi_we=%b stall=%b lo=%h expected 1 0 0 5a5a1234",
                              bus.lo_we, bus.hi_we, bus.stallreq, bus.lo_wdata);
        end
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_random();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
